slave_param_mem: RTL and testbench
==================================

SLAVE_PARAM_MEM -- requirements
Module: slave_param_mem

Interface
REQ-001 Parameters SHALL be: ADDR_W, default 16, serial address length in bits; DATA_W, default 8, data word width; MEM_DEPTH, default 4096, words, power of two; ACK_CYCLES, default 2, acknowledge slot length.
REQ-002 Ports SHALL be:
- CLK  in  1  clock, rising edge
- RSTN  in  1  reset, asynchronous, active-low
- AD_SEL  in  1  slave select from arbiter/decoder
- B_RW  in  1  1=write, 0=read
- B_BUS_OUT  in  1  serial master-to-slave data
- B_BUS_IN  out  1  serial slave-to-master data
- B_ACK  out  1  acknowledge
- B_SBSY  out  1  slave busy
- S_DVALID  out  1  one-cycle pulse, write committed
- S_DOUT  out  DATA_W  last committed write word

Function
REQ-003 States SHALL be IDLE, ADDRESS, ACK_ADDR, WRITE, ACK_WR, READ.
REQ-004 All outputs SHALL be registered; an output attributed to a state cycle is visible from the rising edge that begins that cycle.
REQ-005 IDLE: AD_SEL high at a rising edge SHALL move the block to ADDRESS; otherwise it stays in IDLE with all outputs 0 except S_DOUT, which holds.
REQ-006 ADDRESS: ADDR_W cycles; bit i (LSB first, i=0..ADDR_W-1) SHALL be sampled from B_BUS_OUT at the (i+1)-th edge after entry; after the last bit, the state SHALL be ACK_ADDR.
REQ-007 Word index SHALL be addr[IDX_W-1:0], with IDX_W=log2(MEM_DEPTH); the address is in range iff addr[ADDR_W-1:IDX_W]==0.
REQ-008 ACK_ADDR: ACK_CYCLES cycles; B_ACK SHALL be 1 throughout if in range, 0 throughout if out of range.
REQ-009 At the end of ACK_ADDR: if out of range, the state SHALL become IDLE (NACK, no memory access); otherwise B_RW sampled at the last ACK_ADDR edge SHALL select WRITE (1) or READ (0).
REQ-010 WRITE: DATA_W cycles; B_BUS_OUT SHALL be shifted into a data register, LSB first; then the state SHALL be ACK_WR.
REQ-011 ACK_WR: B_ACK=1 for ACK_CYCLES cycles; on the last edge, mem[idx] and S_DOUT SHALL take the assembled word, and S_DVALID SHALL pulse high for exactly one cycle; the state then returns to IDLE.
REQ-012 READ: DATA_W cycles; B_BUS_IN SHALL present mem[idx] bit k in cycle k (LSB first), then the state returns to IDLE; there is no read acknowledge slot.
REQ-013 B_SBSY SHALL be 1 in every non-IDLE cycle and 0 in IDLE.
REQ-014 AD_SEL and B_RW changes SHALL be ignored outside the sampling points in REQ-005 and REQ-009; a transaction, once started, always runs to completion.
REQ-015 Back-to-back: AD_SEL high in the first IDLE cycle after a transaction SHALL start a new transaction with no extra idle cycle.
REQ-016 The bit counter SHALL be wide enough for max(ADDR_W, DATA_W, ACK_CYCLES) and SHALL clear on every state change; no wrap-around shall occur within a state.
REQ-017 A word of memory SHALL be altered only by a completed ACK_WR.

Reset
REQ-018 RSTN low SHALL immediately force: state IDLE; counter 0; address and data registers 0; B_ACK, B_SBSY, B_BUS_IN, S_DVALID 0; S_DOUT 0.
REQ-019 Memory contents SHALL NOT be reset (RAM-inferable); reads of never-written words return undefined data.
REQ-020 Reset during WRITE or ACK_WR SHALL abort the transaction, leaving mem unchanged and S_DVALID low.

Structure
REQ-021 The state enum and parameter defaults SHALL live in shared package bus_pkg.
REQ-022 The counter SHALL be the sub-module bit_counter (params WIDTH; ports CLK, RSTN, clr, incr, count).
REQ-023 IDX_W SHALL be derived with $clog2 inside the module.

Verification
REQ-024 Write then read: write addr 0x0005, data 0xA5 -> B_ACK high 2+2 cycles, S_DVALID single pulse, S_DOUT=0xA5; read of 0x0005 -> B_BUS_IN serial 1,0,1,0,0,1,0,1.
REQ-025 Out of range: addr 0x1000 with default MEM_DEPTH=4096 -> B_ACK low during the ACK slot, return to IDLE after 2 cycles, memory and S_DOUT unchanged.
REQ-026 Boundary index: write 0x3C to addr 0x0FFF, then 0x11 to 0x0000 -> reads return 0x3C and 0x11 respectively (no aliasing).
REQ-027 Reset mid-WRITE after 4 data bits to a word holding 0x5A -> all outputs 0, state IDLE; later read returns 0x5A.
REQ-028 Back-to-back: AD_SEL held high across two writes (0x01 to addr 1, 0x02 to addr 2) -> second ADDRESS starts the cycle after the first ACK_WR ends; two S_DVALID pulses.
REQ-029 Parameter sweep: DATA_W=16, MEM_DEPTH=256, ACK_CYCLES=3 -> write/read 0xBEEF to addr 0x00FF succeeds with 3-cycle ACK, while addr 0x0100 is NACKed.

Source files
------------

// File: rtl/bus_pkg.sv
// Shared definitions for the serial-bus slave: FSM states, parameter defaults
// and a small sizing helper.
package bus_pkg;

  localparam int unsigned DEF_ADDR_W     = 16;
  localparam int unsigned DEF_DATA_W     = 8;
  localparam int unsigned DEF_MEM_DEPTH  = 4096;
  localparam int unsigned DEF_ACK_CYCLES = 2;

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StAddress = 3'd1,
    StAckAddr = 3'd2,
    StWrite   = 3'd3,
    StAckWr   = 3'd4,
    StRead    = 3'd5
  } state_e;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/bit_counter.sv
// Per-state cycle counter: clears on every state change, otherwise counts up when enabled.
module bit_counter #(
  parameter int unsigned WIDTH = 5
) (
  input  logic             CLK,
  input  logic             RSTN,
  input  logic             clr,
  input  logic             incr,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_d, count_q;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (incr) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/slave_param_mem.sv
// Serial-bus memory slave: LSB-first address phase, ack slot, then a serial write
// (with its own ack slot) or a serial read of one word.
module slave_param_mem
  import bus_pkg::*;
#(
  parameter int unsigned ADDR_W     = DEF_ADDR_W,
  parameter int unsigned DATA_W     = DEF_DATA_W,
  parameter int unsigned MEM_DEPTH  = DEF_MEM_DEPTH,
  parameter int unsigned ACK_CYCLES = DEF_ACK_CYCLES
) (
  input  logic              CLK,
  input  logic              RSTN,
  input  logic              AD_SEL,
  input  logic              B_RW,
  input  logic              B_BUS_OUT,
  output logic              B_BUS_IN,
  output logic              B_ACK,
  output logic              B_SBSY,
  output logic              S_DVALID,
  output logic [DATA_W-1:0] S_DOUT
);

  localparam int unsigned IDX_W = $clog2(MEM_DEPTH);
  localparam int unsigned CNT_W = $clog2(max3(ADDR_W, DATA_W, ACK_CYCLES) + 1);

  localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_W - 1);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] ACK_LAST  = CNT_W'(ACK_CYCLES - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic              ack_q, ack_d;
  logic              sbsy_q, sbsy_d;
  logic              bin_q, bin_d;
  logic              dv_q, dv_d;
  logic              mem_we;
  logic              cnt_clr, cnt_incr;
  logic [CNT_W-1:0]  cnt;
  logic [IDX_W-1:0]  idx;
  logic [DATA_W-1:0] rd_word;

  // No reset on the array so it maps onto plain RAM.
  logic [DATA_W-1:0] mem [MEM_DEPTH];

  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return (a >> IDX_W) == '0;
  endfunction

  assign idx      = addr_q[IDX_W-1:0];
  assign rd_word  = mem[idx];
  assign cnt_clr  = (state_d != state_q);
  assign cnt_incr = (state_q != StIdle);

  bit_counter #(
    .WIDTH(CNT_W)
  ) u_bit_counter (
    .CLK  (CLK),
    .RSTN (RSTN),
    .clr  (cnt_clr),
    .incr (cnt_incr),
    .count(cnt)
  );

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    data_d  = data_q;
    dout_d  = dout_q;
    bin_d   = 1'b0;
    dv_d    = 1'b0;
    mem_we  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (AD_SEL) state_d = StAddress;
      end
      StAddress: begin
        addr_d = {B_BUS_OUT, addr_q[ADDR_W-1:1]};
        if (cnt == ADDR_LAST) state_d = StAckAddr;
      end
      StAckAddr: begin
        if (cnt == ACK_LAST) begin
          if (!in_range(addr_q)) begin
            state_d = StIdle;
          end else if (B_RW) begin
            state_d = StWrite;
          end else begin
            // Bit 0 goes out with the first READ cycle; the rest are shifted from data_q.
            state_d = StRead;
            bin_d   = rd_word[0];
            data_d  = rd_word >> 1;
          end
        end
      end
      StWrite: begin
        data_d = {B_BUS_OUT, data_q[DATA_W-1:1]};
        if (cnt == DATA_LAST) state_d = StAckWr;
      end
      StAckWr: begin
        if (cnt == ACK_LAST) begin
          mem_we  = 1'b1;
          dout_d  = data_q;
          dv_d    = 1'b1;
          state_d = StIdle;
        end
      end
      StRead: begin
        if (cnt == DATA_LAST) begin
          state_d = StIdle;
        end else begin
          bin_d  = data_q[0];
          data_d = data_q >> 1;
        end
      end
      default: state_d = StIdle;
    endcase
    sbsy_d = (state_d != StIdle);
    ack_d  = ((state_d == StAckAddr) && in_range(addr_d)) || (state_d == StAckWr);
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state_q <= StIdle;
      addr_q  <= '0;
      data_q  <= '0;
      dout_q  <= '0;
      ack_q   <= 1'b0;
      sbsy_q  <= 1'b0;
      bin_q   <= 1'b0;
      dv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      dout_q  <= dout_d;
      ack_q   <= ack_d;
      sbsy_q  <= sbsy_d;
      bin_q   <= bin_d;
      dv_q    <= dv_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (mem_we) mem[idx] <= data_q;
  end

  assign B_BUS_IN = bin_q;
  assign B_ACK    = ack_q;
  assign B_SBSY   = sbsy_q;
  assign S_DVALID = dv_q;
  assign S_DOUT   = dout_q;

endmodule

// File: tb/tb_slave_param_mem.sv
// Bench for slave_param_mem: transaction-level expected waveforms for the default
// instance, plus a second instance with DATA_W=16, MEM_DEPTH=256, ACK_CYCLES=3.
module tb_slave_param_mem;

  logic CLK = 1'b0;
  logic RSTN = 1'b1;
  always #5 CLK = ~CLK;

  logic       AD_SEL = 1'b0, B_RW = 1'b0, B_BUS_OUT = 1'b0;
  logic       B_BUS_IN, B_ACK, B_SBSY, S_DVALID;
  logic [7:0] S_DOUT;

  logic        sw_sel = 1'b0, sw_rw = 1'b0, sw_bo = 1'b0;
  logic        sw_bin, sw_ack, sw_sbsy, sw_dv;
  logic [15:0] sw_dout;

  slave_param_mem u_dut (
    .CLK      (CLK),
    .RSTN     (RSTN),
    .AD_SEL   (AD_SEL),
    .B_RW     (B_RW),
    .B_BUS_OUT(B_BUS_OUT),
    .B_BUS_IN (B_BUS_IN),
    .B_ACK    (B_ACK),
    .B_SBSY   (B_SBSY),
    .S_DVALID (S_DVALID),
    .S_DOUT   (S_DOUT)
  );

  slave_param_mem #(
    .ADDR_W    (16),
    .DATA_W    (16),
    .MEM_DEPTH (256),
    .ACK_CYCLES(3)
  ) u_sweep (
    .CLK      (CLK),
    .RSTN     (RSTN),
    .AD_SEL   (sw_sel),
    .B_RW     (sw_rw),
    .B_BUS_OUT(sw_bo),
    .B_BUS_IN (sw_bin),
    .B_ACK    (sw_ack),
    .B_SBSY   (sw_sbsy),
    .S_DVALID (sw_dv),
    .S_DOUT   (sw_dout)
  );

  int checks = 0;
  int errors = 0;

  // Expected outputs for the current cycle of the default instance.
  bit         exp_on = 1'b0;
  logic       e_sbsy, e_ack, e_bin, e_dv;
  logic [7:0] e_dout;

  // Reference model state.
  logic [7:0] m_mem [int];
  logic [7:0] m_dout = 8'h00;
  bit         pend_dv = 1'b0;

  bit         rd_cap = 1'b0;
  logic [7:0] rd_word = 8'h00;
  int         ack_cnt = 0;
  int         dv_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step;
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input logic sel, input logic rw, input logic bo,
                       input logic es, input logic ea, input logic eb);
    AD_SEL    = sel;
    B_RW      = rw;
    B_BUS_OUT = bo;
    e_sbsy    = es;
    e_ack     = ea;
    e_bin     = eb;
    e_dv      = pend_dv;
    e_dout    = m_dout;
    pend_dv   = 1'b0;
    step();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // One full transaction; abort_at >= 0 resets the DUT after that many write bits.
  task automatic main_tx(input logic [15:0] addr, input logic rw, input logic [7:0] wdata,
                         input bit hold, input int abort_at);
    logic       ok;
    logic [7:0] w;
    int         key;
    ok  = (addr[15:12] == 4'h0);
    key = int'(addr[11:0]);
    drive(1'b1, ~rw, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 16; i++) drive(hold | (i % 3 == 0), ~rw, addr[i], 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) drive(hold, (i == 1) ? rw : ~rw, 1'b0, 1'b1, ok, 1'b0);
    if (!ok) return;
    if (rw) begin
      for (int k = 0; k < 8; k++) begin
        if (k == abort_at) begin
          exp_on = 1'b0;
          AD_SEL = 1'b0;
          #2 RSTN = 1'b0;
          #1;
          check("rst_ack", 32'(B_ACK), 32'd0);
          check("rst_sbsy", 32'(B_SBSY), 32'd0);
          check("rst_bus_in", 32'(B_BUS_IN), 32'd0);
          check("rst_dvalid", 32'(S_DVALID), 32'd0);
          check("rst_dout", 32'(S_DOUT), 32'd0);
          step();
          RSTN    = 1'b1;
          m_dout  = 8'h00;
          pend_dv = 1'b0;
          exp_on  = 1'b1;
          return;
        end
        drive(hold, 1'b0, wdata[k], 1'b1, 1'b0, 1'b0);
      end
      for (int i = 0; i < 2; i++) drive(hold, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
      m_mem[key] = wdata;
      m_dout     = wdata;
      pend_dv    = 1'b1;
    end else begin
      w      = m_mem[key];
      rd_cap = 1'b1;
      for (int k = 0; k < 8; k++) drive(hold, 1'b1, 1'b0, 1'b1, 1'b0, w[k]);
      rd_cap = 1'b0;
    end
  endtask

  task automatic sw_tx(input logic [15:0] addr, input logic rw, input logic [15:0] wd,
                       output int acks, output int dvs, output logic [15:0] rword);
    acks   = 0;
    dvs    = 0;
    rword  = 16'h0;
    sw_sel = 1'b1;
    sw_rw  = ~rw;
    step();
    sw_sel = 1'b0;
    for (int i = 0; i < 16; i++) begin
      sw_bo = addr[i];
      step();
    end
    sw_rw = rw;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      if (sw_ack === 1'b1) acks++;
      step();
    end
    if (addr[15:8] != 8'h00) begin
      @(negedge CLK);
      check("sweep_nack_idle", 32'(sw_sbsy), 32'd0);
      step();
      return;
    end
    if (rw) begin
      for (int k = 0; k < 16; k++) begin
        sw_bo = wd[k];
        step();
      end
      for (int i = 0; i < 3; i++) begin
        @(negedge CLK);
        if (sw_ack === 1'b1) acks++;
        step();
      end
      @(negedge CLK);
      if (sw_dv === 1'b1) dvs++;
      step();
    end else begin
      for (int k = 0; k < 16; k++) begin
        @(negedge CLK);
        rword = {sw_bin, rword[15:1]};
        step();
      end
    end
  endtask

  int          s_acks, s_dvs;
  logic [15:0] s_word;

  initial begin
    fork
      forever begin
        @(negedge CLK);
        if (rd_cap) rd_word = {B_BUS_IN, rd_word[7:1]};
        if (B_ACK === 1'b1) ack_cnt++;
        if (S_DVALID === 1'b1) dv_cnt++;
        if (exp_on) begin
          check("sbsy", 32'(B_SBSY), 32'(e_sbsy));
          check("ack", 32'(B_ACK), 32'(e_ack));
          check("bus_in", 32'(B_BUS_IN), 32'(e_bin));
          check("dvalid", 32'(S_DVALID), 32'(e_dv));
          check("dout", 32'(S_DOUT), 32'(e_dout));
        end
      end
    join_none

    #2 RSTN = 1'b0;
    #1;
    check("reset_ack", 32'(B_ACK), 32'd0);
    check("reset_sbsy", 32'(B_SBSY), 32'd0);
    check("reset_bus_in", 32'(B_BUS_IN), 32'd0);
    check("reset_dvalid", 32'(S_DVALID), 32'd0);
    check("reset_dout", 32'(S_DOUT), 32'd0);
    step();
    RSTN   = 1'b1;
    exp_on = 1'b1;
    idle(2);

    // Write then read 0x0005 / 0xA5.
    ack_cnt = 0;
    dv_cnt  = 0;
    main_tx(16'h0005, 1'b1, 8'hA5, 1'b0, -1);
    idle(1);
    check("wr_ack_cycles", 32'(ack_cnt), 32'd4);
    check("wr_dvalid_pulses", 32'(dv_cnt), 32'd1);
    check("wr_dout", 32'(S_DOUT), 32'hA5);
    main_tx(16'h0005, 1'b0, 8'h00, 1'b0, -1);
    idle(1);
    check("rd_serial_a5", 32'(rd_word), 32'hA5);

    // Out of range write is NACKed and leaves everything alone.
    ack_cnt = 0;
    dv_cnt  = 0;
    main_tx(16'h1000, 1'b1, 8'hEE, 1'b0, -1);
    idle(2);
    check("oor_ack_cycles", 32'(ack_cnt), 32'd0);
    check("oor_dvalid", 32'(dv_cnt), 32'd0);
    check("oor_dout", 32'(S_DOUT), 32'hA5);
    main_tx(16'hF005, 1'b0, 8'h00, 1'b0, -1);
    idle(1);
    main_tx(16'h0005, 1'b0, 8'h00, 1'b0, -1);
    idle(1);
    check("oor_mem_kept", 32'(rd_word), 32'hA5);

    // Boundary indices must not alias.
    main_tx(16'h0FFF, 1'b1, 8'h3C, 1'b0, -1);
    main_tx(16'h0000, 1'b1, 8'h11, 1'b0, -1);
    idle(1);
    main_tx(16'h0FFF, 1'b0, 8'h00, 1'b0, -1);
    check("rd_0fff", 32'(rd_word), 32'h3C);
    main_tx(16'h0000, 1'b0, 8'h00, 1'b0, -1);
    check("rd_0000", 32'(rd_word), 32'h11);
    idle(1);

    // Reset in the middle of a write keeps the old word.
    main_tx(16'h0007, 1'b1, 8'h5A, 1'b0, -1);
    idle(1);
    main_tx(16'h0007, 1'b1, 8'hFF, 1'b0, 4);
    idle(2);
    main_tx(16'h0007, 1'b0, 8'h00, 1'b0, -1);
    idle(1);
    check("rst_abort_mem", 32'(rd_word), 32'h5A);

    // Back-to-back writes with AD_SEL held high.
    dv_cnt = 0;
    main_tx(16'h0001, 1'b1, 8'h01, 1'b1, -1);
    main_tx(16'h0002, 1'b1, 8'h02, 1'b1, -1);
    idle(1);
    check("b2b_dvalid_pulses", 32'(dv_cnt), 32'd2);
    main_tx(16'h0001, 1'b0, 8'h00, 1'b0, -1);
    check("b2b_rd1", 32'(rd_word), 32'h01);
    main_tx(16'h0002, 1'b0, 8'h00, 1'b0, -1);
    check("b2b_rd2", 32'(rd_word), 32'h02);
    idle(2);
    exp_on = 1'b0;

    // Second instance with different parameters.
    sw_tx(16'h00FF, 1'b1, 16'hBEEF, s_acks, s_dvs, s_word);
    check("sweep_wr_acks", 32'(s_acks), 32'd6);
    check("sweep_wr_dvalid", 32'(s_dvs), 32'd1);
    check("sweep_dout", 32'(sw_dout), 32'hBEEF);
    sw_tx(16'h00FF, 1'b0, 16'h0000, s_acks, s_dvs, s_word);
    check("sweep_rd_word", 32'(s_word), 32'hBEEF);
    check("sweep_rd_acks", 32'(s_acks), 32'd3);
    sw_tx(16'h0100, 1'b1, 16'h1234, s_acks, s_dvs, s_word);
    check("sweep_nack_acks", 32'(s_acks), 32'd0);
    check("sweep_nack_dout", 32'(sw_dout), 32'hBEEF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
